// File: rtl/edge_delay_meter.sv
// Stimulus-to-response latency monitor.
// Counts clock cycles from a stimulus edge to the first response edge.
module edge_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stim,
  input  logic             resp,
  input  logic             arm,
  input  logic             clr_stats,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] delay,
  output logic             edge_rise,
  output logic [CNT_W-1:0] min_delay,
  output logic [CNT_W-1:0] max_delay,
  output logic [CNT_W-1:0] meas_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stim_q, stim_d;
  logic             resp_q, resp_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             stim_edge;
  logic             resp_edge;
  logic             upd;

  assign stim_edge = stim ^ stim_q;
  assign resp_edge = resp ^ resp_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stim_d    = stim;
    resp_d    = resp;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    delay_d   = delay_q;
    rise_d    = rise_q;
    upd       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (stim_edge) begin
          if (resp_edge) begin
            delay_d = '0;
            rise_d  = resp;
            done_d  = 1'b1;
            upd     = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = ONE;
            state_d = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (resp_edge) begin
          delay_d = cnt_q;
          rise_d  = resp;
          done_d  = 1'b1;
          upd     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A clear on the same edge as a stats update takes priority.
  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    if (clr_stats) begin
      min_d   = ONES;
      max_d   = '0;
      count_d = '0;
    end else if (upd) begin
      if (delay_d < min_q) min_d = delay_d;
      if (delay_d > max_q) max_d = delay_d;
      if (count_q != ONES) count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      stim_q    <= stim;
      resp_q    <= resp;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      delay_q   <= '0;
      rise_q    <= 1'b0;
      min_q     <= ONES;
      max_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stim_q    <= stim_d;
      resp_q    <= resp_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      delay_q   <= delay_d;
      rise_q    <= rise_d;
      min_q     <= min_d;
      max_q     <= max_d;
      count_q   <= count_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign delay      = delay_q;
  assign edge_rise  = rise_q;
  assign min_delay  = min_q;
  assign max_delay  = max_q;
  assign meas_count = count_q;

endmodule
